// File: rtl/cic_integrator_chain.sv
// Time-multiplexed cascade of two's-complement integrators (integrator half of a CIC decimator).
// Optional build macro CIC_INTEG_ROUND_EN selects round-half-up on the output slice instead of truncation.
module cic_integrator_chain #(
  parameter int DATA_WIDTH_INP = 8,
  parameter int DATA_WIDTH_OUT = 9,
  parameter int ACC_WIDTH      = 24,
  parameter int NUM_STAGES     = 3,
  parameter int NUM_CHANNELS   = 1,
  localparam int CHAN_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                      inp_samp_str,
  output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                      out_samp_str,
  output logic [CHAN_WIDTH-1:0]     out_samp_chan
);

  localparam int CHAN_DEPTH = 1 << CHAN_WIDTH;

  typedef logic [ACC_WIDTH-1:0] acc_t;

  acc_t                  r_acc      [NUM_STAGES][CHAN_DEPTH];
  logic                  r_pipeStr  [NUM_STAGES];
  logic [CHAN_WIDTH-1:0] r_pipeChan [NUM_STAGES];
  logic [CHAN_WIDTH-1:0] r_chanCnt;
  logic [DATA_WIDTH_OUT-1:0] r_outData;

  logic                  w_stgStr  [NUM_STAGES];
  logic [CHAN_WIDTH-1:0] w_stgChan [NUM_STAGES];
  acc_t                  w_stgIn   [NUM_STAGES];
  acc_t                  w_stgSum  [NUM_STAGES];

  logic signed [DATA_WIDTH_INP-1:0] w_inpSigned;
  acc_t                             w_inpExt;
  logic [CHAN_WIDTH-1:0]            w_chanNext;
  logic [DATA_WIDTH_OUT-1:0]        w_outSlice;

  assign w_inpSigned = inp_samp_data;
  assign w_inpExt    = ACC_WIDTH'(w_inpSigned);
  assign w_chanNext  = (r_chanCnt == CHAN_WIDTH'(NUM_CHANNELS - 1)) ? '0 : r_chanCnt + 1'b1;

  // Each stage after the first consumes the value its predecessor wrote on the previous edge,
  // addressed by the channel tag travelling with that strobe.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign w_stgStr[g]  = inp_samp_str;
      assign w_stgChan[g] = r_chanCnt;
      assign w_stgIn[g]   = w_inpExt;
    end else begin : g_next
      assign w_stgStr[g]  = r_pipeStr[g-1];
      assign w_stgChan[g] = r_pipeChan[g-1];
      assign w_stgIn[g]   = r_acc[g-1][r_pipeChan[g-1]];
    end
    assign w_stgSum[g] = r_acc[g][w_stgChan[g]] + w_stgIn[g];
  end

  // Adding half an output LSB before slicing equals adding the first dropped bit to the slice.
`ifdef CIC_INTEG_ROUND_EN
  if (ACC_WIDTH > DATA_WIDTH_OUT) begin : g_round
    assign w_outSlice = w_stgSum[NUM_STAGES-1][ACC_WIDTH-1 -: DATA_WIDTH_OUT]
                      + DATA_WIDTH_OUT'(w_stgSum[NUM_STAGES-1][ACC_WIDTH-DATA_WIDTH_OUT-1]);
  end else begin : g_trunc
    assign w_outSlice = w_stgSum[NUM_STAGES-1][ACC_WIDTH-1 -: DATA_WIDTH_OUT];
  end
`else
  assign w_outSlice = w_stgSum[NUM_STAGES-1][ACC_WIDTH-1 -: DATA_WIDTH_OUT];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chanCnt <= '0;
      r_outData <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_pipeStr[k]  <= 1'b0;
        r_pipeChan[k] <= '0;
        for (int c = 0; c < CHAN_DEPTH; c++) r_acc[k][c] <= '0;
      end
    end else if (clear) begin
      r_chanCnt <= '0;
      r_outData <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_pipeStr[k]  <= 1'b0;
        r_pipeChan[k] <= '0;
        for (int c = 0; c < CHAN_DEPTH; c++) r_acc[k][c] <= '0;
      end
    end else begin
      if (inp_samp_str) r_chanCnt <= w_chanNext;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_pipeStr[k] <= w_stgStr[k];
        if (w_stgStr[k]) begin
          r_pipeChan[k]              <= w_stgChan[k];
          r_acc[k][w_stgChan[k]]     <= w_stgSum[k];
        end
      end
      if (w_stgStr[NUM_STAGES-1]) r_outData <= w_outSlice;
    end
  end

  // The last stage's strobe/tag registers double as the output strobe and held channel.
  assign out_samp_data = r_outData;
  assign out_samp_str  = r_pipeStr[NUM_STAGES-1];
  assign out_samp_chan = r_pipeChan[NUM_STAGES-1];

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Bench for cic_integrator_chain: three configurations driven together, checked against
// an arithmetic model of the integrator cascade with a fixed-latency output schedule.
module tb_cic_integrator_chain;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic [7:0]  inpA, inpB, inpC;
  logic        strA, strB, strC;
  logic [23:0] outA;
  logic        oStrA;
  logic [0:0]  oChanA;
  logic [3:0]  outB;
  logic        oStrB;
  logic [0:0]  oChanB;
  logic [15:0] outC;
  logic        oStrC;
  logic [1:0]  oChanC;

  always #5 clk = ~clk;

  // A: N=3,C=1,ACC=OUT=24   B: N=1,C=1,ACC=8,OUT=4   C: N=2,C=3,ACC=OUT=16
  cic_integrator_chain #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(24), .ACC_WIDTH(24),
                         .NUM_STAGES(3), .NUM_CHANNELS(1)) dutA (
    .clk(clk), .reset_n(reset_n), .clear(clear), .inp_samp_data(inpA), .inp_samp_str(strA),
    .out_samp_data(outA), .out_samp_str(oStrA), .out_samp_chan(oChanA));
  cic_integrator_chain #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(4), .ACC_WIDTH(8),
                         .NUM_STAGES(1), .NUM_CHANNELS(1)) dutB (
    .clk(clk), .reset_n(reset_n), .clear(clear), .inp_samp_data(inpB), .inp_samp_str(strB),
    .out_samp_data(outB), .out_samp_str(oStrB), .out_samp_chan(oChanB));
  cic_integrator_chain #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(16), .ACC_WIDTH(16),
                         .NUM_STAGES(2), .NUM_CHANNELS(3)) dutC (
    .clk(clk), .reset_n(reset_n), .clear(clear), .inp_samp_data(inpC), .inp_samp_str(strC),
    .out_samp_data(outC), .out_samp_str(oStrC), .out_samp_chan(oChanC));

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;

  int pN[3] = '{3, 1, 2};
  int pC[3] = '{1, 1, 3};
  int pA[3] = '{24, 8, 16};
  int pO[3] = '{24, 4, 16};

  longint mAcc[3][3][3];
  int     nextCh[3];
  int     expStr[3], expChan[3], expData[3];

  typedef struct {int due; int ch; int data;} pend_t;
  pend_t pq[3][$];

  function automatic logic signed [31:0] obsStr(int i);
    case (i)
      0: return oStrA;
      1: return oStrB;
      default: return oStrC;
    endcase
  endfunction

  function automatic logic signed [31:0] obsChan(int i);
    case (i)
      0: return oChanA;
      1: return oChanB;
      default: return oChanC;
    endcase
  endfunction

  function automatic logic signed [31:0] obsData(int i);
    case (i)
      0: return $signed(outA);
      1: return $signed(outB);
      default: return $signed(outC);
    endcase
  endfunction

  // Integrate one sample through every stage in one go, then slice (and optionally round).
  function automatic int modelOut(int i, int ch, int x);
    longint mask = (longint'(1) << pA[i]) - 1;
    longint v = x;
    int raw;
    for (int k = 0; k < pN[i]; k++) begin
      mAcc[i][k][ch] = (mAcc[i][k][ch] + v) & mask;
      v = mAcc[i][k][ch];
    end
`ifdef CIC_INTEG_ROUND_EN
    if (pA[i] > pO[i]) v = (v + (longint'(1) << (pA[i] - pO[i] - 1))) & mask;
`endif
    raw = int'(v >> (pA[i] - pO[i]));
    if (raw >= (1 << (pO[i] - 1))) raw -= (1 << pO[i]);
    return raw;
  endfunction

  task automatic modelFlush();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 3; c++) mAcc[i][k][c] = 0;
      pq[i].delete();
      nextCh[i] = 0;
      expStr[i] = 0;
      expChan[i] = 0;
      expData[i] = 0;
    end
  endtask

  // One clock: drive inputs, advance the model past the edge, land 1ns after the edge.
  task automatic applyStimulus(input bit s0, input int d0, input bit s1, input int d1,
                               input bit s2, input int d2, input bit clr);
    bit s[3];
    int d[3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    strA = s0; inpA = d0[7:0];
    strB = s1; inpB = d1[7:0];
    strC = s2; inpC = d2[7:0];
    clear = clr;
    @(posedge clk);
    cyc++;
    if (clr) modelFlush();
    else begin
      for (int i = 0; i < 3; i++) begin
        if (s[i]) begin
          pend_t p;
          logic signed [7:0] x8;
          x8 = d[i][7:0];
          p.ch = nextCh[i];
          nextCh[i] = (nextCh[i] + 1) % pC[i];
          p.data = modelOut(i, p.ch, int'(x8));
          p.due = cyc + pN[i] - 1;
          pq[i].push_back(p);
        end
        if (pq[i].size() > 0 && pq[i][0].due == cyc) begin
          expStr[i] = 1;
          expChan[i] = pq[i][0].ch;
          expData[i] = pq[i][0].data;
          void'(pq[i].pop_front());
        end else expStr[i] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear = 1'b0;
    strA = 0; strB = 0; strC = 0;
    inpA = 0; inpB = 0; inpC = 0;
    modelFlush();
    #3;
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (obsStr(i) !== 0 || obsChan(i) !== 0 || obsData(i) !== 0) begin
        nMismatched++;
        $display("[TB] FAIL reset_state dut%0d: got str/chan/data %0d/%0d/%0d, want 0/0/0",
                 i, obsStr(i), obsChan(i), obsData(i));
      end
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
        nMismatched++;
        $display("[TB] FAIL after_reset dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                 obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
      end
    end
  endtask

  task automatic test_impulse();
    int impulseExp[5] = '{1, 3, 6, 10, 15};
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 7; j++) begin
      applyStimulus(1, (j == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      nCompared++;
      if (oStrA !== (j >= 2) || (j >= 2 && $signed(outA) !== impulseExp[(j >= 2) ? j - 2 : 0])) begin
        nMismatched++;
        $display("[TB] FAIL impulse step %0d: got str=%0d data=%0d, want str=%0d data=%0d", j,
                 oStrA, $signed(outA), (j >= 2), (j >= 2) ? impulseExp[(j >= 2) ? j - 2 : 0] : 0);
      end
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
          nMismatched++;
          $display("[TB] FAIL impulse_model dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                   obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_round();
`ifdef CIC_INTEG_ROUND_EN
    int want24 = 2;
    int want127 = -8;
`else
    int want24 = 1;
    int want127 = 7;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 24, 0, 0, 0);
    nCompared++;
    if (oStrB !== 1'b1 || $signed(outB) !== want24) begin
      nMismatched++;
      $display("[TB] FAIL slice_24: got str=%0d data=%0d, want str=1 data=%0d", oStrB, $signed(outB), want24);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 127, 0, 0, 0);
    nCompared++;
    if (oStrB !== 1'b1 || $signed(outB) !== want127) begin
      nMismatched++;
      $display("[TB] FAIL slice_127: got str=%0d data=%0d, want str=1 data=%0d", oStrB, $signed(outB), want127);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(0, 0, (j < 4), 100, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
          nMismatched++;
          $display("[TB] FAIL wrap dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                   obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
        end
      end
    end
  endtask

  task automatic test_channels();
    int chData[3] = '{1, 0, 2};
    int ch0Exp[3] = '{1, 3, 6};
    int ch0Got[$];
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(0, 0, 0, 0, (j < 9), chData[j % 3], 0);
      if (j >= 1) begin
        nCompared++;
        if (oStrC !== 1'b1 || oChanC !== 2'((j - 1) % 3)) begin
          nMismatched++;
          $display("[TB] FAIL chan_seq step %0d: got str=%0d chan=%0d, want str=1 chan=%0d",
                   j, oStrC, oChanC, (j - 1) % 3);
        end
      end
      if (oStrC === 1'b1 && oChanC === 2'd0) ch0Got.push_back(int'($signed(outC)));
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
          nMismatched++;
          $display("[TB] FAIL channels dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                   obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
        end
      end
    end
    nCompared++;
    if (ch0Got.size() != 3 || ch0Got[0] != ch0Exp[0] || ch0Got[1] != ch0Exp[1] || ch0Got[2] != ch0Exp[2]) begin
      nMismatched++;
      $display("[TB] FAIL ch0_series: got %0d values %p, want 3 values %p", ch0Got.size(), ch0Got, ch0Exp);
    end
  endtask

  task automatic test_clear();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 5; j++)
      applyStimulus(1, $urandom_range(0, 255) - 128, 0, 0, 1, $urandom_range(0, 255) - 128, 0);
    applyStimulus(1, 50, 1, 50, 1, 50, 1);
    nCompared++;
    if (oStrA !== 0 || outA !== 0 || oStrC !== 0 || outC !== 0 || oChanC !== 0) begin
      nMismatched++;
      $display("[TB] FAIL clear_flush: got A str=%0d data=%0d C str=%0d data=%0d chan=%0d, want all 0",
               oStrA, outA, oStrC, outC, oChanC);
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus((j == 0), 7, 0, 0, (j == 0), 7, 0);
      if (j == 2) begin
        nCompared++;
        if (oStrA !== 1'b1 || $signed(outA) !== 7 || oChanA !== 0) begin
          nMismatched++;
          $display("[TB] FAIL clear_next: got str=%0d data=%0d chan=%0d, want 1/7/0", oStrA, $signed(outA), oChanA);
        end
      end
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
          nMismatched++;
          $display("[TB] FAIL clear dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                   obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int j = 0; j < 4; j++)
      applyStimulus(1, 20 + j, 1, 30, 1, 40 + j, 0);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (obsStr(i) !== 0 || obsChan(i) !== 0 || obsData(i) !== 0) begin
        nMismatched++;
        $display("[TB] FAIL async_reset dut%0d: got %0d/%0d/%0d, want 0/0/0", i, obsStr(i), obsChan(i), obsData(i));
      end
    end
    modelFlush();
    #1 reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      applyStimulus((j == 0), 9, (j == 0), 9, (j == 0), 5, 0);
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
          nMismatched++;
          $display("[TB] FAIL post_reset dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                   obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 255) - 128,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 255) - 128,
                    $urandom_range(0, 9) < 8, $urandom_range(0, 255) - 128,
                    $urandom_range(0, 39) == 0);
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (obsStr(i) !== expStr[i] || obsChan(i) !== expChan[i] || obsData(i) !== expData[i]) begin
          nMismatched++;
          $display("[TB] FAIL random dut%0d cyc %0d: got %0d/%0d/%0d, want %0d/%0d/%0d", i, cyc,
                   obsStr(i), obsChan(i), obsData(i), expStr[i], expChan[i], expData[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_wrap_round();
    test_channels();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
